// File: rtl/snn_pkg.sv
// Shared constants and types for the tiny SNN network: geometry, index widths
// and the time-step scheduler state encoding.
package snn_pkg;

  localparam int N           = 5;
  localparam int T           = 4;
  localparam int TS          = N * T;
  localparam int TIMEOUT_DEF = 255;

  localparam int BLK_W = $clog2(T);
  localparam int TS_W  = $clog2(TS + 1);
  // Byte width of ts_idx as seen from the AXI register map.
  localparam int NN    = (TS_W + 7) / 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    LEAK,
    STEP,
    DONE
  } sched_state_t;

endpackage

// File: rtl/snn_watchdog.sv
// Saturating cycle counter that flags the cycle on which the count reaches TIMEOUT.
module snn_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (count_en && (count != CW'(TIMEOUT))) begin
      count <= count + CW'(1);
    end
  end

  // High during the enabled cycle that brings the count up to TIMEOUT.
  assign expired = count_en && (count >= CW'(TIMEOUT - 1));

endmodule

// File: rtl/snn_step_scheduler.sv
// Time-step sequencer: walks the T neuron blocks, then leaks and advances
// the step index, TS times per run, with a per-block completion watchdog.
module snn_step_scheduler
  import snn_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic             blk_req,
  input  logic             blk_ack,
  output logic [BLK_W-1:0] blk_idx,
  input  logic             blk_done,
  output logic             leak_en,
  output logic             step_done,
  output logic [TS_W-1:0]  ts_idx,
  output logic             busy,
  output logic             run_done,
  output logic             err
);

  sched_state_t state;
  logic         xfer;
  logic         in_wait;
  logic         wd_expired;

  assign xfer    = (state == ISSUE) && blk_ack;
  assign in_wait = (state == WAIT);

  snn_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (xfer),
    .count_en(in_wait),
    .expired (wd_expired)
  );

  // Outputs are registered alongside the state so each strobe lines up with its state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      blk_req   <= 1'b0;
      blk_idx   <= '0;
      leak_en   <= 1'b0;
      step_done <= 1'b0;
      ts_idx    <= '0;
      busy      <= 1'b0;
      run_done  <= 1'b0;
      err       <= 1'b0;
    end else begin
      blk_req   <= 1'b0;
      leak_en   <= 1'b0;
      step_done <= 1'b0;
      run_done  <= 1'b0;
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state   <= ISSUE;
              ts_idx  <= '0;
              blk_idx <= '0;
              err     <= 1'b0;
              blk_req <= 1'b1;
              busy    <= 1'b1;
            end
          end
          ISSUE: begin
            if (blk_ack) begin
              state <= WAIT;
            end else begin
              blk_req <= 1'b1;
            end
          end
          WAIT: begin
            if (blk_done) begin
              if (blk_idx == BLK_W'(T - 1)) begin
                state   <= LEAK;
                leak_en <= 1'b1;
              end else begin
                state   <= ISSUE;
                blk_idx <= blk_idx + BLK_W'(1);
                blk_req <= 1'b1;
              end
            end else if (wd_expired) begin
              state <= IDLE;
              busy  <= 1'b0;
              err   <= 1'b1;
            end
          end
          LEAK: begin
            state     <= STEP;
            step_done <= 1'b1;
          end
          STEP: begin
            ts_idx  <= ts_idx + TS_W'(1);
            blk_idx <= '0;
            if (ts_idx == TS_W'(TS - 1)) begin
              state    <= DONE;
              run_done <= 1'b1;
            end else begin
              state   <= ISSUE;
              blk_req <= 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_snn_step_scheduler.sv
// Bench for snn_step_scheduler: a phase-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_snn_step_scheduler;
  import snn_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, abort = 1'b0, blk_ack = 1'b0, blk_done = 1'b0;
  logic blk_req, leak_en, step_done, busy, run_done, err;
  logic [BLK_W-1:0] blk_idx;
  logic [TS_W-1:0]  ts_idx;

  int checks = 0, errors = 0;

  // Responder configuration and observation counters.
  bit hang = 0, spur = 0, xfer_last = 0;
  int stall_left = 0, st_ts = -1, st_blk = -1;
  int xfers = 0, leaks = 0, steps = 0, dones = 0, busy_cyc = 0;
  int req_run = 0, max_run = 0;
  int cnt_blk [T];

  // Reference model: phase k within a step (even<2T issue, odd<2T wait,
  // 2T leak, 2T+1 step, 2T+2 run complete).
  bit model_ok = 0, running = 0, m_err = 0;
  int k = 0, m_ts = 0, m_blk = 0, wd = 0;

  always #5 clk = ~clk;

  snn_step_scheduler dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .blk_req  (blk_req),
    .blk_ack  (blk_ack),
    .blk_idx  (blk_idx),
    .blk_done (blk_done),
    .leak_en  (leak_en),
    .step_done(step_done),
    .ts_idx   (ts_idx),
    .busy     (busy),
    .run_done (run_done),
    .err      (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return 32'({blk_req, blk_idx, leak_en, step_done, ts_idx, busy, run_done, err});
  endfunction

  initial forever begin
    @(posedge clk);
    if (reset) begin
      running = 0; k = 0; m_ts = 0; m_blk = 0; m_err = 0; wd = 0;
      model_ok = 1;
    end else if (!running) begin
      if (start && !abort) begin
        running = 1; k = 0; m_ts = 0; m_blk = 0; m_err = 0;
      end
    end else if (abort) begin
      running = 0;
    end else if (k < 2 * T && k % 2 == 0) begin
      if (blk_ack) begin k++; wd = 0; end
    end else if (k < 2 * T) begin
      if (blk_done) begin
        if (m_blk == T - 1) k = 2 * T;
        else begin k++; m_blk++; end
      end else begin
        wd++;
        if (wd >= TIMEOUT_DEF) begin running = 0; m_err = 1; end
      end
    end else if (k == 2 * T) begin
      k++;
    end else if (k == 2 * T + 1) begin
      m_ts++;
      m_blk = 0;
      k = (m_ts == TS) ? 2 * T + 2 : 0;
    end else begin
      running = 0;
    end
  end

  initial forever begin
    logic [31:0] exp;
    logic [TS_W-1:0] ets;
    logic [BLK_W-1:0] eblk;
    @(negedge clk);
    if (model_ok) begin
      ets  = m_ts[TS_W-1:0];
      eblk = m_blk[BLK_W-1:0];
      exp = 32'({running && k < 2 * T && k % 2 == 0, eblk,
                 running && k == 2 * T, running && k == 2 * T + 1,
                 ets, running, running && k == 2 * T + 2, m_err});
      check("model_cycle", dut_vec(), exp);
      check("strobe_onehot", 32'($onehot0({leak_en, step_done, run_done})), 32'd1);
      if (leak_en) leaks++;
      if (step_done) steps++;
      if (run_done) dones++;
      if (busy) busy_cyc++;
    end
  end

  // Block responder: ack while requested, done on the cycle after a transfer.
  initial forever begin
    bit hold;
    @(negedge clk);
    hold = hang && (blk_idx == 1) && (ts_idx == 0);
    blk_done = (xfer_last && !hold) || (spur && blk_req);
    if (blk_req && stall_left > 0 && ts_idx == st_ts && blk_idx == st_blk) begin
      blk_ack = 1'b0;
      stall_left--;
    end else begin
      blk_ack = spur ? 1'b1 : blk_req;
    end
    xfer_last = blk_req && blk_ack;
    if (xfer_last) begin
      xfers++;
      cnt_blk[blk_idx]++;
    end
    if (blk_req) begin
      req_run++;
      if (req_run > max_run) max_run = req_run;
    end else begin
      req_run = 0;
    end
  end

  task automatic clear_counts();
    xfers = 0; leaks = 0; steps = 0; dones = 0; busy_cyc = 0; max_run = 0;
    for (int i = 0; i < T; i++) cnt_blk[i] = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int n = 0;
    while (busy && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  task automatic wait_ts(input int ts, input bit want_wait, input int max_cyc);
    int n = 0;
    while (n < max_cyc && !(ts_idx == ts && (want_wait ? (busy && !blk_req && !leak_en && !step_done)
                                                       : leak_en))) begin
      @(negedge clk);
      n++;
    end
    check("wait_ts_reached", 32'(n < max_cyc), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", dut_vec(), 32'd0);
    reset = 1'b0;

    // Nominal run.
    clear_counts();
    pulse_start();
    check("start_busy", 32'(busy), 32'd1);
    wait_idle("nom_idle", 400);
    check("nom_xfers", 32'(xfers), 32'd80);
    check("nom_blk3_xfers", 32'(cnt_blk[3]), 32'd20);
    check("nom_leaks", 32'(leaks), 32'd20);
    check("nom_steps", 32'(steps), 32'd20);
    check("nom_run_done", 32'(dones), 32'd1);
    check("nom_busy_cycles", 32'(busy_cyc), 32'd201);
    check("nom_ts_idx", 32'(ts_idx), 32'd20);
    check("nom_err", 32'(err), 32'd0);
    check("model_ts_pin", 32'(m_ts), 32'd20);

    // Backpressure on block 2 of step 5.
    clear_counts();
    st_ts = 5; st_blk = 2; stall_left = 7;
    pulse_start();
    wait_idle("bp_idle", 400);
    check("bp_xfers", 32'(xfers), 32'd80);
    check("bp_steps", 32'(steps), 32'd20);
    check("bp_max_req_run", 32'(max_run), 32'd8);
    check("bp_busy_cycles", 32'(busy_cyc), 32'd208);
    check("bp_run_done", 32'(dones), 32'd1);

    // Watchdog timeout on block 1 of step 0.
    clear_counts();
    hang = 1;
    pulse_start();
    wait_idle("to_idle", 400);
    check("to_err", 32'(err), 32'd1);
    check("to_run_done", 32'(dones), 32'd0);
    check("to_busy_cycles", 32'(busy_cyc), 32'd258);
    check("to_ts_idx", 32'(ts_idx), 32'd0);
    check("to_blk_idx", 32'(blk_idx), 32'd1);
    check("to_xfers", 32'(xfers), 32'd2);
    check("model_err_pin", 32'(m_err), 32'd1);
    hang = 0;
    pulse_start();
    check("restart_clears_err", 32'(err), 32'd0);
    wait_idle("restart_idle", 400);
    check("restart_ts_idx", 32'(ts_idx), 32'd20);

    // Abort during LEAK of step 3, then start together with abort.
    clear_counts();
    pulse_start();
    wait_ts(3, 1'b0, 100);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_ts_idx", 32'(ts_idx), 32'd3);
    check("ab_blk_idx", 32'(blk_idx), 32'd3);
    check("ab_steps", 32'(steps), 32'd3);
    check("ab_leaks", 32'(leaks), 32'd4);
    check("ab_run_done", 32'(dones), 32'd0);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", 32'(busy), 32'd0);
    check("start_abort_ts", 32'(ts_idx), 32'd3);

    // Spurious done in ISSUE and start mid-run.
    clear_counts();
    spur = 1; st_ts = 2; st_blk = 0; stall_left = 1;
    pulse_start();
    wait_ts(7, 1'b1, 200);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("sp_idle", 400);
    spur = 0;
    check("sp_xfers", 32'(xfers), 32'd80);
    check("sp_steps", 32'(steps), 32'd20);
    check("sp_leaks", 32'(leaks), 32'd20);
    check("sp_run_done", 32'(dones), 32'd1);
    check("sp_busy_cycles", 32'(busy_cyc), 32'd202);

    // Reset in WAIT of step 10, then a fresh run.
    pulse_start();
    wait_ts(10, 1'b1, 200);
    reset = 1'b1;
    @(negedge clk);
    check("midrun_reset_outputs", dut_vec(), 32'd0);
    reset = 1'b0;
    clear_counts();
    pulse_start();
    wait_idle("rs_idle", 400);
    check("rs_xfers", 32'(xfers), 32'd80);
    check("rs_steps", 32'(steps), 32'd20);
    check("rs_ts_idx", 32'(ts_idx), 32'd20);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
